// File: rtl/typedefs_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I load/store size codes and the funct3 legality check.
package typedefs_pkg;

    // Number of byte lanes on the data bus; lane logic is built for a 32-bit bus.
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // RV32I funct3 size/sign codes shared by loads and stores.
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Stores only know SB/SH/SW; loads additionally know LBU/LHU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        end else begin
            bad = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W) &&
                  (f3 != F3_BU) && (f3 != F3_HU);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the LSU: store byte enables and lane
// replication, load lane selection with sign/zero extension, and the
// natural-alignment check for the access size.
module lsu_lane_align
    import typedefs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lanes,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);

    // funct3[1:0] encodes the access size for both loads and stores.
    logic [1:0] size;
    assign size = funct3[1:0];

    // Read word split into its byte lanes so a lane can be picked by address.
    logic [7:0] rbyte [LANES];

    // Store data: byte and half are replicated so the right lane is always
    // populated regardless of address; the byte enables pick the live lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
        assign rbyte[gi] = rdata[8*gi +: 8];

        always_comb begin
            unique case (size)
                2'd0:    wdata_lanes[8*gi +: 8] = wdata[7:0];
                2'd1:    wdata_lanes[8*gi +: 8] = wdata[8*(gi%2) +: 8];
                default: wdata_lanes[8*gi +: 8] = wdata[8*gi +: 8];
            endcase
        end
    end

    // Selected byte and (half-aligned) halfword from the read word.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    assign sel_byte = rbyte[addr_lo];
    assign sel_half = {rbyte[{addr_lo[1], 1'b1}], rbyte[{addr_lo[1], 1'b0}]};

    // Byte enables shifted into the addressed lanes; word accesses use all four.
    always_comb begin
        unique case (size)
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
    end

    // Halves must be 2-byte aligned, words 4-byte aligned; bytes never misalign.
    always_comb begin
        unique case (size)
            2'd1:    misaligned = addr_lo[0];
            2'd2:    misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Load result: lane selected by address, then sign or zero extended.
    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_BU:   rdata_ext = {{(XLEN-8){1'b0}}, sel_byte};
            F3_H:    rdata_ext = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_HU:   rdata_ext = {{(XLEN-16){1'b0}}, sel_half};
            F3_W:    rdata_ext = rdata;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one load or store from the execute stage, rejects
// illegal or misaligned accesses without touching the bus, issues a
// word-aligned request with byte enables, waits for read data on loads and
// returns a one-cycle completion pulse.
module lsu
    import typedefs_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,

    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,

    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t        state_q,      state_d;
    logic [2:0]        funct3_q,     funct3_d;
    logic [1:0]        addr_lo_q,    addr_lo_d;
    logic              mem_we_q,     mem_we_d;
    logic [AWIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [3:0]        mem_be_q,     mem_be_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q,   resp_err_d;

    // The lane aligner is shared: in IDLE it looks at the incoming request to
    // build the bus fields; afterwards it looks at the captured access so the
    // load extension uses the original funct3 and byte offset.
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_misaligned;

    assign al_funct3  = (state_q == IDLE) ? req_funct3    : funct3_q;
    assign al_addr_lo = (state_q == IDLE) ? req_addr[1:0] : addr_lo_q;

    lsu_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3      (al_funct3),
        .addr_lo     (al_addr_lo),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .be          (al_be),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata),
        .misaligned  (al_misaligned)
    );

    logic req_bad;
    assign req_bad = f3_illegal(req_we, req_funct3) || al_misaligned;

    // Next-state and captured-register logic; everything holds unless updated.
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d     = req_funct3;
                    addr_lo_d    = req_addr[1:0];
                    resp_rdata_d = '0;
                    if (req_bad) begin
                        // Rejected accesses complete immediately, bus untouched.
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        resp_err_d  = 1'b0;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[AWIDTH-1:2], 2'b00};
                        mem_be_d    = req_we ? al_be : 4'b1111;
                        mem_wdata_d = req_we ? al_wdata : '0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = mem_we_q ? RESP : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    resp_rdata_d = al_rdata;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured request registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Handshake outputs are pure state decodes, so they follow reset immediately.
    assign req_ready  = (state_q == IDLE);
    assign mem_valid  = (state_q == REQ);
    assign resp_valid = (state_q == RESP);

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
